seq_divider: RTL and testbench

//  Multi-cycle radix-2 restoring divider. It replaces the single-cycle combinational divide path in the execute stage.

---
 rtl/seq_divider_pkg.sv | 10 +
 rtl/seq_divider_div_step.sv | 24 ++
 rtl/seq_divider.sv | 173 +++++++++++++++++
 tb/tb_seq_divider.sv | 361 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_divider_pkg.sv
// rtl/seq_divider_pkg.sv - state encoding shared by the sequential divider
package seq_divider_pkg;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_CALC = 2'd1,
        DIV_DONE = 2'd2
    } div_state_e;

endpackage

// File: rtl/seq_divider_div_step.sv
// rtl/seq_divider_div_step.sv - one restoring division iteration, purely combinational
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic [WIDTH-1:0] divisor_i,
    input  logic             bit_i,
    output logic [WIDTH-1:0] rem_o,
    output logic             q_o
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    // The held remainder is always below the divisor, so it fits WIDTH bits;
    // the shifted trial value needs one more and the borrow is diff[WIDTH].
    always_comb begin
        shifted = {rem_i, bit_i};
        diff    = shifted - {1'b0, divisor_i};
        q_o     = ~diff[WIDTH];
        rem_o   = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
    end

endmodule

// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - multi-cycle radix-2 restoring divider with ready/valid, tag and flush
module seq_divider
    import seq_divider_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_is_unsigned,
    input  logic             in_use_mod,
    input  logic [TAG_W-1:0] in_tag,
    input  logic [WIDTH-1:0] src1,
    input  logic [WIDTH-1:0] src2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_div0
);

    localparam int               CNT_W   = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

    div_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             prep_q, prep_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] dvd_q, dvd_d;
    logic [WIDTH-1:0] dsr_q, dsr_d;
    logic             uns_q, uns_d;
    logic             mod_q, mod_d;
    logic             neg_quo_q, neg_quo_d;
    logic             neg_rem_q, neg_rem_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic [TAG_W-1:0] out_tag_q, out_tag_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             div0_q, div0_d;

    logic [WIDTH-1:0] step_rem;
    logic             step_bit;
    logic [WIDTH-1:0] quo;

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem_i     (rem_q),
        .divisor_i (dsr_q),
        .bit_i     (dvd_q[WIDTH-1]),
        .rem_o     (step_rem),
        .q_o       (step_bit)
    );

    // Quotient bits shift into the dividend register as dividend bits leave it.
    assign quo        = {dvd_q[WIDTH-2:0], step_bit};
    assign in_ready   = (state_q == DIV_IDLE);
    assign out_valid  = (state_q == DIV_DONE);
    assign out_result = res_q;
    assign out_tag    = out_tag_q;
    assign out_div0   = div0_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        prep_d    = prep_q;
        rem_d     = rem_q;
        dvd_d     = dvd_q;
        dsr_d     = dsr_q;
        uns_d     = uns_q;
        mod_d     = mod_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        tag_d     = tag_q;
        out_tag_d = out_tag_q;
        res_d     = res_q;
        div0_d    = div0_q;

        if (flush) begin
            state_d = DIV_IDLE;
        end else begin
            case (state_q)
                DIV_IDLE: begin
                    if (in_valid) begin
                        state_d = DIV_CALC;
                        prep_d  = 1'b1;
                        cnt_d   = CNT_W'(WIDTH-1);
                        rem_d   = '0;
                        dvd_d   = src1;
                        dsr_d   = src2;
                        uns_d   = in_is_unsigned;
                        mod_d   = in_use_mod;
                        tag_d   = in_tag;
                    end
                end
                DIV_CALC: begin
                    // First CALC cycle resolves short-cuts and takes magnitudes,
                    // keeping the compare and negate logic off the accept path.
                    if (prep_q) begin
                        prep_d    = 1'b0;
                        neg_quo_d = !uns_q && (dvd_q[WIDTH-1] ^ dsr_q[WIDTH-1]);
                        neg_rem_d = !uns_q && dvd_q[WIDTH-1];
                        if (dsr_q == '0) begin
                            state_d   = DIV_DONE;
                            res_d     = mod_q ? dvd_q : '1;
                            div0_d    = 1'b1;
                            out_tag_d = tag_q;
                        end else if (!uns_q && dvd_q == MIN_VAL && dsr_q == '1) begin
                            state_d   = DIV_DONE;
                            res_d     = mod_q ? '0 : MIN_VAL;
                            div0_d    = 1'b0;
                            out_tag_d = tag_q;
                        end else begin
                            if (!uns_q && dvd_q[WIDTH-1]) dvd_d = -dvd_q;
                            if (!uns_q && dsr_q[WIDTH-1]) dsr_d = -dsr_q;
                        end
                    end else begin
                        rem_d = step_rem;
                        dvd_d = quo;
                        if (cnt_q == '0) begin
                            state_d   = DIV_DONE;
                            div0_d    = 1'b0;
                            out_tag_d = tag_q;
                            if (mod_q) res_d = neg_rem_q ? -step_rem : step_rem;
                            else       res_d = neg_quo_q ? -quo : quo;
                        end else begin
                            cnt_d = cnt_q - 1'b1;
                        end
                    end
                end
                DIV_DONE: begin
                    if (out_ready) state_d = DIV_IDLE;
                end
                default: state_d = DIV_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= DIV_IDLE;
            cnt_q     <= '0;
            prep_q    <= 1'b0;
            rem_q     <= '0;
            dvd_q     <= '0;
            dsr_q     <= '0;
            uns_q     <= 1'b0;
            mod_q     <= 1'b0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            tag_q     <= '0;
            out_tag_q <= '0;
            res_q     <= '0;
            div0_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            prep_q    <= prep_d;
            rem_q     <= rem_d;
            dvd_q     <= dvd_d;
            dsr_q     <= dsr_d;
            uns_q     <= uns_d;
            mod_q     <= mod_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            tag_q     <= tag_d;
            out_tag_q <= out_tag_d;
            res_q     <= res_d;
            div0_q    <= div0_d;
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// tb/tb_seq_divider.sv - scoreboard bench for seq_divider at WIDTH=32 and WIDTH=8
module tb_seq_divider;

    typedef struct {
        logic        uns;
        logic        mod;
        logic [3:0]  tag;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        div0;
        int          lat;
    } op_t;

    typedef struct {
        logic [31:0] res;
        logic [3:0]  tag;
        logic        div0;
        int          lat;
    } obs_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        resetn = 1'b0, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0, sel8 = 1'b0;
    logic        in_is_unsigned = 1'b0, in_use_mod = 1'b0;
    logic [3:0]  in_tag = '0;
    logic [31:0] src1 = '0, src2 = '0;

    logic        in_ready32, out_valid32, out_div0_32, in_ready8, out_valid8, out_div0_8;
    logic [31:0] out_result32;
    logic [7:0]  out_result8;
    logic [3:0]  out_tag32, out_tag8;
    logic        in_ready, out_valid, out_div0;
    logic [31:0] out_result;
    logic [3:0]  out_tag;

    assign in_ready   = sel8 ? in_ready8   : in_ready32;
    assign out_valid  = sel8 ? out_valid8  : out_valid32;
    assign out_div0   = sel8 ? out_div0_8  : out_div0_32;
    assign out_result = sel8 ? {24'h0, out_result8} : out_result32;
    assign out_tag    = sel8 ? out_tag8    : out_tag32;

    seq_divider #(.WIDTH(32), .TAG_W(4)) u_dut32 (
        .clk(clk), .resetn(resetn), .flush(flush),
        .in_valid(in_valid & ~sel8), .in_ready(in_ready32),
        .in_is_unsigned(in_is_unsigned), .in_use_mod(in_use_mod), .in_tag(in_tag),
        .src1(src1), .src2(src2),
        .out_valid(out_valid32), .out_ready(out_ready), .out_result(out_result32),
        .out_tag(out_tag32), .out_div0(out_div0_32)
    );

    seq_divider #(.WIDTH(8), .TAG_W(4)) u_dut8 (
        .clk(clk), .resetn(resetn), .flush(flush),
        .in_valid(in_valid & sel8), .in_ready(in_ready8),
        .in_is_unsigned(in_is_unsigned), .in_use_mod(in_use_mod), .in_tag(in_tag),
        .src1(src1[7:0]), .src2(src2[7:0]),
        .out_valid(out_valid8), .out_ready(out_ready), .out_result(out_result8),
        .out_tag(out_tag8), .out_div0(out_div0_8)
    );

    obs_t scb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic void model8(input logic uns, input logic mod, input logic [7:0] a,
                                   input logic [7:0] b, output logic [7:0] r,
                                   output logic d0, output int lat);
        logic signed [7:0] sa, sd;
        sa = a;
        sd = b;
        d0 = 1'b0;
        lat = 9;
        if (b == 8'h00) begin
            d0 = 1'b1; lat = 1; r = mod ? a : 8'hFF;
        end else if (!uns && a == 8'h80 && b == 8'hFF) begin
            lat = 1; r = mod ? 8'h00 : 8'h80;
        end else if (uns) begin
            r = mod ? a % b : a / b;
        end else begin
            r = mod ? sa % sd : sa / sd;
        end
    endfunction

    task automatic issue(input logic uns, input logic mod, input logic [3:0] tag,
                         input logic [31:0] a, input logic [31:0] b);
        int k;
        k = 0;
        while (!in_ready && k < 200) begin @(negedge clk); k++; end
        if (!in_ready) begin
            n_tests++; n_fail++;
            $display("FAIL issue_ready: in_ready=%0b required 1", in_ready);
        end
        in_is_unsigned = uns; in_use_mod = mod; in_tag = tag; src1 = a; src2 = b;
        in_valid = 1'b1;
        @(posedge clk); @(negedge clk);
        in_valid = 1'b0;
        src1 = $urandom; src2 = $urandom;
    endtask

    task automatic wait_out(output int lat);
        lat = -1;
        for (int k = 1; k <= 100; k++) begin
            @(posedge clk); @(negedge clk);
            if (out_valid) begin lat = k; break; end
        end
    endtask

    task automatic retire();
        out_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic run_op(input op_t op, output obs_t ob);
        int lat;
        scb.push_back('{res: op.res, tag: op.tag, div0: op.div0, lat: op.lat});
        issue(op.uns, op.mod, op.tag, op.a, op.b);
        wait_out(lat);
        ob.lat = lat; ob.res = out_result; ob.tag = out_tag; ob.div0 = out_div0;
        if (lat > 0) retire();
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        n_tests++;
        if ({in_ready, out_valid, out_div0} !== 3'b100) begin
            n_fail++;
            $display("FAIL reset_flags: ready/valid/div0=%b required 100", {in_ready, out_valid, out_div0});
        end
        n_tests++;
        if (out_result !== 32'h0 || out_tag !== 4'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: result=%h tag=%h required 0/0", out_result, out_tag);
        end
    endtask

    task automatic test_divide();
        op_t  ops[8];
        obs_t ob, e;
        ops = '{
            '{1'b1, 1'b0, 4'd3, 32'd100,        32'd7,          32'd14,         1'b0, 33},
            '{1'b1, 1'b1, 4'd3, 32'd100,        32'd7,          32'd2,          1'b0, 33},
            '{1'b0, 1'b0, 4'd1, 32'hFFFFFFF9,   32'd2,          32'hFFFFFFFD,   1'b0, 33},
            '{1'b0, 1'b1, 4'd2, 32'hFFFFFFF9,   32'd2,          32'hFFFFFFFF,   1'b0, 33},
            '{1'b0, 1'b0, 4'd4, 32'd7,          32'hFFFFFFFE,   32'hFFFFFFFD,   1'b0, 33},
            '{1'b0, 1'b1, 4'd5, 32'd7,          32'hFFFFFFFE,   32'd1,          1'b0, 33},
            '{1'b1, 1'b0, 4'd6, 32'hFFFFFFFF,   32'd1,          32'hFFFFFFFF,   1'b0, 33},
            '{1'b0, 1'b0, 4'd7, 32'h80000000,   32'd1,          32'h80000000,   1'b0, 33}
        };
        foreach (ops[i]) begin
            run_op(ops[i], ob);
            e = scb.pop_front();
            n_tests++;
            if (ob.lat !== e.lat) begin n_fail++; $display("FAIL divide_lat[%0d]: got %0d required %0d", i, ob.lat, e.lat); end
            n_tests++;
            if (ob.res !== e.res) begin n_fail++; $display("FAIL divide_result[%0d]: got %h required %h", i, ob.res, e.res); end
            n_tests++;
            if (ob.tag !== e.tag || ob.div0 !== e.div0) begin
                n_fail++; $display("FAIL divide_tag_div0[%0d]: got %h/%b required %h/%b", i, ob.tag, ob.div0, e.tag, e.div0);
            end
        end
    endtask

    task automatic test_shortcuts();
        op_t  ops[6];
        obs_t ob, e;
        ops = '{
            '{1'b1, 1'b0, 4'd8,  32'd5,         32'd0,        32'hFFFFFFFF, 1'b1, 1},
            '{1'b1, 1'b1, 4'd9,  32'd5,         32'd0,        32'd5,        1'b1, 1},
            '{1'b0, 1'b0, 4'd10, 32'h80000000,  32'hFFFFFFFF, 32'h80000000, 1'b0, 1},
            '{1'b0, 1'b1, 4'd11, 32'h80000000,  32'hFFFFFFFF, 32'h00000000, 1'b0, 1},
            '{1'b0, 1'b1, 4'd12, 32'hFFFFFFF0,  32'd0,        32'hFFFFFFF0, 1'b1, 1},
            '{1'b1, 1'b1, 4'd13, 32'h80000000,  32'hFFFFFFFF, 32'h80000000, 1'b0, 33}
        };
        foreach (ops[i]) begin
            run_op(ops[i], ob);
            e = scb.pop_front();
            n_tests++;
            if (ob.lat !== e.lat) begin n_fail++; $display("FAIL short_lat[%0d]: got %0d required %0d", i, ob.lat, e.lat); end
            n_tests++;
            if (ob.res !== e.res) begin n_fail++; $display("FAIL short_result[%0d]: got %h required %h", i, ob.res, e.res); end
            n_tests++;
            if (ob.tag !== e.tag || ob.div0 !== e.div0) begin
                n_fail++; $display("FAIL short_tag_div0[%0d]: got %h/%b required %h/%b", i, ob.tag, ob.div0, e.tag, e.div0);
            end
        end
    endtask

    task automatic test_backpressure();
        obs_t e;
        int   lat;
        scb.push_back('{res: 32'd14, tag: 4'd5, div0: 1'b0, lat: 33});
        issue(1'b1, 1'b0, 4'd5, 32'd100, 32'd7);
        wait_out(lat);
        e = scb.pop_front();
        n_tests++;
        if (lat !== e.lat) begin n_fail++; $display("FAIL bp_lat: got %0d required %0d", lat, e.lat); end
        for (int c = 0; c < 10; c++) begin
            n_tests++;
            if ({out_valid, in_ready, out_result, out_tag} !== {1'b1, 1'b0, e.res, e.tag}) begin
                n_fail++;
                $display("FAIL bp_hold[%0d]: valid/ready/result/tag=%b/%b/%h/%h required 1/0/%h/%h",
                         c, out_valid, in_ready, out_result, out_tag, e.res, e.tag);
            end
            @(posedge clk); @(negedge clk);
        end
        retire();
        n_tests++;
        if ({out_valid, in_ready} !== 2'b01) begin
            n_fail++; $display("FAIL bp_retire: valid/ready=%b%b required 01", out_valid, in_ready);
        end
        scb.push_back('{res: 32'd3, tag: 4'd6, div0: 1'b0, lat: 33});
        issue(1'b1, 1'b0, 4'd6, 32'd9, 32'd3);
        n_tests++;
        if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_next_accept: in_ready=%b required 0", in_ready); end
        wait_out(lat);
        e = scb.pop_front();
        n_tests++;
        if (lat !== e.lat || out_result !== e.res || out_tag !== e.tag) begin
            n_fail++;
            $display("FAIL bp_next_result: lat/result/tag=%0d/%h/%h required %0d/%h/%h", lat, out_result, out_tag, e.lat, e.res, e.tag);
        end
        if (lat > 0) retire();
    endtask

    task automatic test_flush();
        obs_t ob, e;
        op_t  op;
        logic seen;
        int   lat;
        issue(1'b1, 1'b0, 4'd2, 32'd100, 32'd7);
        repeat (16) begin @(posedge clk); @(negedge clk); end
        flush = 1'b1;
        @(posedge clk); @(negedge clk);
        flush = 1'b0;
        n_tests++;
        if ({out_valid, in_ready} !== 2'b01) begin
            n_fail++; $display("FAIL flush_calc: valid/ready=%b%b required 01", out_valid, in_ready);
        end
        seen = 1'b0;
        repeat (40) begin @(posedge clk); @(negedge clk); seen |= out_valid; end
        n_tests++;
        if (seen !== 1'b0) begin n_fail++; $display("FAIL flush_no_output: out_valid seen=%b required 0", seen); end
        op = '{1'b1, 1'b0, 4'd9, 32'd9, 32'd3, 32'd3, 1'b0, 33};
        run_op(op, ob);
        e = scb.pop_front();
        n_tests++;
        if (ob.lat !== e.lat || ob.res !== e.res || ob.tag !== e.tag) begin
            n_fail++;
            $display("FAIL flush_after: lat/result/tag=%0d/%h/%h required %0d/%h/%h", ob.lat, ob.res, ob.tag, e.lat, e.res, e.tag);
        end
        in_valid = 1'b1; flush = 1'b1; in_is_unsigned = 1'b1; in_use_mod = 1'b0; src1 = 32'd8; src2 = 32'd2;
        @(posedge clk); @(negedge clk);
        in_valid = 1'b0; flush = 1'b0;
        seen = out_valid;
        repeat (3) begin @(posedge clk); @(negedge clk); seen |= out_valid; end
        n_tests++;
        if ({in_ready, seen} !== 2'b10) begin
            n_fail++; $display("FAIL flush_idle_accept: ready/valid_seen=%b%b required 10", in_ready, seen);
        end
        issue(1'b1, 1'b0, 4'd1, 32'd5, 32'd0);
        wait_out(lat);
        flush = 1'b1;
        @(posedge clk); @(negedge clk);
        flush = 1'b0;
        n_tests++;
        if (lat !== 1 || {out_valid, in_ready} !== 2'b01) begin
            n_fail++; $display("FAIL flush_done: lat=%0d valid/ready=%b%b required 1 01", lat, out_valid, in_ready);
        end
    endtask

    task automatic test_reset_mid();
        int lat;
        issue(1'b1, 1'b0, 4'd3, 32'd100, 32'd7);
        repeat (5) begin @(posedge clk); @(negedge clk); end
        resetn = 1'b0;
        #1;
        n_tests++;
        if ({out_valid, in_ready} !== 2'b01) begin
            n_fail++; $display("FAIL reset_mid_calc: valid/ready=%b%b required 01", out_valid, in_ready);
        end
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        issue(1'b1, 1'b0, 4'd7, 32'd5, 32'd0);
        wait_out(lat);
        resetn = 1'b0;
        #1;
        n_tests++;
        if (lat !== 1 || {out_valid, out_div0, out_tag} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_mid_done: lat=%0d valid/div0/tag=%b/%b/%h required 1 0/0/0", lat, out_valid, out_div0, out_tag);
        end
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_width8_random();
        op_t         op;
        obs_t        ob, e;
        logic [7:0]  r;
        logic        d0;
        int          lat;
        logic [15:0] fixed[4];
        fixed = '{16'h80FF, 16'h8001, 16'h7F00, 16'hFFFF};
        sel8 = 1'b1;
        for (int i = 0; i < 48; i++) begin
            op.uns = (i < 8) ? i[0] : 1'($urandom);
            op.mod = (i < 8) ? i[1] : 1'($urandom);
            op.tag = 4'($urandom);
            if (i < 8) begin
                op.a = {24'($urandom), fixed[i/2][15:8]};
                op.b = {24'($urandom), fixed[i/2][7:0]};
            end else begin
                op.a = $urandom;
                op.b = $urandom;
                case ($urandom_range(0, 7))
                    0: op.b[7:0] = 8'h00;
                    1: op.b[7:0] = 8'hFF;
                    default: ;
                endcase
            end
            model8(op.uns, op.mod, op.a[7:0], op.b[7:0], r, d0, lat);
            op.res = {24'h0, r}; op.div0 = d0; op.lat = lat;
            run_op(op, ob);
            e = scb.pop_front();
            n_tests++;
            if (ob.lat !== e.lat || ob.res !== e.res || ob.tag !== e.tag || ob.div0 !== e.div0) begin
                n_fail++;
                $display("FAIL w8[%0d] u=%b m=%b a=%h b=%h: lat/res/tag/div0=%0d/%h/%h/%b required %0d/%h/%h/%b",
                         i, op.uns, op.mod, op.a[7:0], op.b[7:0], ob.lat, ob.res[7:0], ob.tag, ob.div0,
                         e.lat, e.res[7:0], e.tag, e.div0);
            end
        end
        sel8 = 1'b0;
    endtask

    initial begin
        test_reset();
        test_divide();
        test_shortcuts();
        test_backpressure();
        test_flush();
        test_reset_mid();
        test_width8_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
